// File: rtl/program_counter.sv
// Instruction-fetch program counter: increment, absolute jump, or signed relative branch,
// with a one-edge warm-up bubble after every reset so fetch starts from a settled address.
module program_counter #(
  parameter int                 WIDTH        = 8,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
  parameter int                 OFFSET_W     = WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable_increment,
  input  logic                       load_en,
  input  logic [WIDTH-1:0]           load_addr,
  input  logic                       branch_en,
  input  logic signed [OFFSET_W-1:0] branch_off,
  input  logic                       stall,
  output logic [WIDTH-1:0]           pc,
  output logic [WIDTH-1:0]           pc_plus1,
  output logic                       pc_valid
);

  logic             warm;
  logic [WIDTH-1:0] pc_next;

  // Sign-extend the offset to the combined width so either operand may be the wider one;
  // the sum is taken modulo 2^WIDTH by keeping only the low bits.
  function automatic logic [WIDTH-1:0] add_offset(
    input logic [WIDTH-1:0]           base,
    input logic signed [OFFSET_W-1:0] off
  );
    logic signed [WIDTH+OFFSET_W-1:0] base_ext;
    logic signed [WIDTH+OFFSET_W-1:0] off_ext;
    logic signed [WIDTH+OFFSET_W-1:0] sum;
    base_ext = {{OFFSET_W{1'b0}}, base};
    off_ext  = {{WIDTH{off[OFFSET_W-1]}}, off};
    sum      = base_ext + off_ext;
    return sum[WIDTH-1:0];
  endfunction

  assign pc_plus1 = pc + WIDTH'(1);

  always_comb begin
    pc_next = pc;
    if (warm && !stall) begin
      if (load_en)               pc_next = load_addr;
      else if (branch_en)        pc_next = add_offset(pc, branch_off);
      else if (enable_increment) pc_next = pc_plus1;
    end
  end

  // Register stage: warm gates the update above, so the first edge after reset holds pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_VECTOR;
      warm     <= 1'b0;
      pc_valid <= 1'b0;
    end else begin
      pc       <= pc_next;
      warm     <= 1'b1;
      pc_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: the driver queues the expected post-edge state,
// a monitor pops and compares it just after each rising edge.
module tb_program_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable_increment = 1'b0;
  logic       load_en = 1'b0;
  logic [7:0] load_addr = 8'h00;
  logic       branch_en = 1'b0;
  logic [7:0] branch_off = 8'h00;
  logic       stall = 1'b0;
  logic [7:0] pc;
  logic [7:0] pc_plus1;
  logic       pc_valid;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] plus1;
    logic       valid;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  program_counter #(.WIDTH(8), .RESET_VECTOR(8'h00), .OFFSET_W(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable_increment (enable_increment),
    .load_en          (load_en),
    .load_addr        (load_addr),
    .branch_en        (branch_en),
    .branch_off       (branch_off),
    .stall            (stall),
    .pc               (pc),
    .pc_plus1         (pc_plus1),
    .pc_valid         (pc_valid)
  );

  always #5 clk = ~clk;

  // Drive one edge's inputs at the falling edge and queue what the next rising edge must produce.
  task automatic step(input logic r, input logic inc, input logic ld, input logic [7:0] addr,
                      input logic br, input logic [7:0] off, input logic st,
                      input logic [7:0] e_pc, input logic [7:0] e_plus1, input logic e_vld,
                      input string name);
    exp_t e;
    @(negedge clk);
    reset = r; enable_increment = inc; load_en = ld; load_addr = addr;
    branch_en = br; branch_off = off; stall = st;
    e.pc = e_pc; e.plus1 = e_plus1; e.valid = e_vld; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, req);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check8({e.name, ".pc"},       pc,              e.pc);
        check8({e.name, ".pc_plus1"}, pc_plus1,        e.plus1);
        check8({e.name, ".pc_valid"}, {7'b0, pc_valid}, {7'b0, e.valid});
      end
    end
  end

  initial begin : driver
    int waited;
    //   rst inc ld addr   br off    st   pc     plus1  vld
    step(1, 0, 0, 8'h00, 0, 8'h00, 0,   8'h00, 8'h01, 0, "reset");
    step(0, 0, 0, 8'h00, 0, 8'h00, 0,   8'h00, 8'h01, 1, "warmup");
    step(0, 1, 0, 8'h00, 0, 8'h00, 0,   8'h01, 8'h02, 1, "inc1");
    step(0, 1, 0, 8'h00, 0, 8'h00, 0,   8'h02, 8'h03, 1, "inc2");
    step(0, 1, 0, 8'h00, 0, 8'h00, 0,   8'h03, 8'h04, 1, "inc3");
    step(0, 1, 0, 8'h00, 0, 8'h00, 0,   8'h04, 8'h05, 1, "inc4");
    step(1, 1, 0, 8'h00, 0, 8'h00, 0,   8'h00, 8'h01, 0, "reset_mid_inc");
    step(0, 1, 0, 8'h00, 0, 8'h00, 0,   8'h00, 8'h01, 1, "bubble_inc");
    step(0, 1, 0, 8'h00, 0, 8'h00, 0,   8'h01, 8'h02, 1, "post_bubble_inc");
    step(0, 0, 1, 8'hFF, 0, 8'h00, 0,   8'hFF, 8'h00, 1, "load_ff");
    step(0, 1, 0, 8'h00, 0, 8'h00, 0,   8'h00, 8'h01, 1, "wrap_ff_00");
    step(0, 1, 0, 8'h00, 0, 8'h00, 0,   8'h01, 8'h02, 1, "wrap_00_01");
    step(0, 1, 1, 8'h40, 0, 8'h00, 0,   8'h40, 8'h41, 1, "load_over_inc");
    step(0, 0, 0, 8'h00, 1, 8'hFC, 0,   8'h3C, 8'h3D, 1, "branch_m4");
    step(0, 1, 1, 8'h80, 0, 8'h00, 1,   8'h3C, 8'h3D, 1, "stall1");
    step(0, 1, 1, 8'h80, 0, 8'h00, 1,   8'h3C, 8'h3D, 1, "stall2");
    step(0, 1, 1, 8'h80, 1, 8'h05, 1,   8'h3C, 8'h3D, 1, "stall3");
    step(0, 1, 0, 8'h00, 0, 8'h00, 0,   8'h3D, 8'h3E, 1, "resume_inc");
    step(0, 0, 1, 8'h80, 0, 8'h00, 0,   8'h80, 8'h81, 1, "resume_load");
    step(0, 0, 1, 8'h01, 0, 8'h00, 0,   8'h01, 8'h02, 1, "load_01");
    step(0, 1, 0, 8'h00, 1, 8'hFE, 0,   8'hFF, 8'h00, 1, "branch_m2_wrap");
    step(0, 0, 0, 8'h00, 1, 8'h05, 0,   8'h04, 8'h05, 1, "branch_p5_wrap");
    step(0, 0, 0, 8'h00, 0, 8'h00, 0,   8'h04, 8'h05, 1, "hold");
    step(0, 1, 1, 8'h10, 1, 8'h01, 0,   8'h10, 8'h11, 1, "load_over_branch");
    step(1, 1, 1, 8'h55, 0, 8'h00, 1,   8'h00, 8'h01, 0, "reset_in_stall");
    step(0, 0, 1, 8'h55, 0, 8'h00, 0,   8'h00, 8'h01, 1, "bubble_load");
    step(0, 0, 1, 8'h55, 0, 8'h00, 0,   8'h55, 8'h56, 1, "load_55");
    @(negedge clk);
    reset = 0; enable_increment = 0; load_en = 0; branch_en = 0; stall = 0;
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
